// File: rtl/nios_mul_pkg.sv
// Shared definitions for the NIOS pipelined multiplier.
//  - op encodings for the low word (MUL) and the three high-word variants
//  - control part of the stage-1 payload (op plus operand sign bits)
//  - legality checks for the DATA_W / PIPE_STAGES parameters
package nios_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // Width-independent part of the stage-1 payload. The partial products and
  // operands depend on DATA_W, so the full payload struct is declared in the
  // top where that parameter is visible, and embeds this one.
  typedef struct packed {
    logic [1:0] op;
    logic       src1_neg;
    logic       src2_neg;
  } mul_ctl_t;

  function automatic bit data_w_ok(input int unsigned w);
    return (w >= 8) && (w <= 64) && ((w % 2) == 0);
  endfunction

  function automatic bit pipe_stages_ok(input int unsigned n);
    return (n >= 2) && (n <= 4);
  endfunction

endpackage

// File: rtl/nios_mul_pp_stage.sv
// One stall-aware pipeline register (valid + payload).
//  clk, reset  : clock, synchronous active-high reset (clears valid and data)
//  stall       : downstream output is valid but not accepted
//  up_valid    : upstream beat present
//  up_data     : upstream payload
//  valid, data : registered beat
// The register loads whenever it is empty or the pipe is not stalled. While
// stalled an empty register loads only a bubble, so a held upstream beat is
// never copied forward (which would duplicate it). Data only changes when a
// real beat arrives, keeping the last value visible across bubbles.
module nios_mul_pp_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic take;
  assign take = up_valid & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (~valid | ~stall) begin
      valid <= take;
      if (take) data <= up_data;
    end
  end

endmodule

// File: rtl/nios_mul_pp_pipe.sv
// Pipelined half-width partial-product multiplier for the NIOS execute path.
//  Parameters: DATA_W (even, 8..64), PIPE_STAGES (2..4, input-to-output latency)
//  clk, reset  : clock, synchronous active-high reset
//  in_valid/in_ready, in_op, in_src1, in_src2 : operand beat
//    in_op 00 MUL (low word), 01 MULXUU, 10 MULXSU, 11 MULXSS (high word)
//  out_valid/out_ready, out_result            : result beat
//  acc_clr     : zero the accumulator (only with MUL_CELL_ACCUM_EN)
// Optional feature macro: MUL_CELL_ACCUM_EN adds an accumulator that sums the
// low word of every MUL result delivered; out_result then shows the new sum.
// Stage 1 registers the four partial products, stage 2 recombines and applies
// the signed high-word correction, further stages are plain delay.
module nios_mul_pp_pipe
  import nios_mul_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  input  logic              acc_clr
);

  localparam int unsigned H  = DATA_W / 2;
  localparam int unsigned ND = PIPE_STAGES - 1;   // stages after stage 1

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("nios_mul_pp_pipe: DATA_W must be even and in 8..64");
  end
  if (!pipe_stages_ok(PIPE_STAGES)) begin : g_bad_stages
    $error("nios_mul_pp_pipe: PIPE_STAGES must be in 2..4");
  end

  typedef struct packed {
    logic [DATA_W-1:0] pll;
    logic [DATA_W-1:0] plh;
    logic [DATA_W-1:0] phl;
    logic [DATA_W-1:0] phh;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    mul_ctl_t          ctl;
  } s1_pay_t;

`ifdef MUL_CELL_ACCUM_EN
  localparam int unsigned W2 = DATA_W + 2;   // result word plus op
`else
  localparam int unsigned W2 = DATA_W;
`endif

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- stage 1: partial products ----------------
  s1_pay_t s1_d, s1_q;
  logic    s1_v;

  always_comb begin
    s1_d              = '0;
    s1_d.pll          = {{H{1'b0}}, in_src1[H-1:0]}      * {{H{1'b0}}, in_src2[H-1:0]};
    s1_d.plh          = {{H{1'b0}}, in_src1[H-1:0]}      * {{H{1'b0}}, in_src2[DATA_W-1:H]};
    s1_d.phl          = {{H{1'b0}}, in_src1[DATA_W-1:H]} * {{H{1'b0}}, in_src2[H-1:0]};
    s1_d.phh          = {{H{1'b0}}, in_src1[DATA_W-1:H]} * {{H{1'b0}}, in_src2[DATA_W-1:H]};
    s1_d.src1         = in_src1;
    s1_d.src2         = in_src2;
    s1_d.ctl.op       = in_op;
    s1_d.ctl.src1_neg = in_src1[DATA_W-1];
    s1_d.ctl.src2_neg = in_src2[DATA_W-1];
  end

  nios_mul_pp_stage #(.W($bits(s1_pay_t))) u_stage1 (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .up_valid (in_valid & in_ready),
    .up_data  (s1_d),
    .valid    (s1_v),
    .data     (s1_q)
  );

  // ---------------- stage 2: combine and correct ----------------
  logic [2*DATA_W-1:0] u;
  logic [DATA_W-1:0]   u_hi;
  logic [DATA_W-1:0]   corr_b;
  logic [DATA_W-1:0]   corr_a;
  logic [DATA_W-1:0]   word;
  logic [W2-1:0]       s2_d;

  always_comb begin
    u = {{DATA_W{1'b0}}, s1_q.pll}
      + ({{DATA_W{1'b0}}, s1_q.plh} << H)
      + ({{DATA_W{1'b0}}, s1_q.phl} << H)
      + {s1_q.phh, {DATA_W{1'b0}}};
    u_hi = u[2*DATA_W-1:DATA_W];
    // Signed operands carry weight -2^(DATA_W-1) in their MSB; removing the
    // unsigned excess from the high word is one subtraction per negative operand.
    corr_b = s1_q.ctl.src1_neg ? s1_q.src2 : '0;
    corr_a = s1_q.ctl.src2_neg ? s1_q.src1 : '0;
    case (s1_q.ctl.op)
      OP_MUL:    word = u[DATA_W-1:0];
      OP_MULXUU: word = u_hi;
      OP_MULXSU: word = u_hi - corr_b;
      OP_MULXSS: word = u_hi - corr_b - corr_a;
      default:   word = u[DATA_W-1:0];
    endcase
  end

`ifdef MUL_CELL_ACCUM_EN
  assign s2_d = {s1_q.ctl.op, word};
`else
  assign s2_d = word;
`endif

  // ---------------- stage 2 register and delay stages ----------------
  logic [W2-1:0] sd [ND];
  logic          sv [ND];

  for (genvar j = 0; j < ND; j++) begin : g_stage
    if (j == 0) begin : g_first
      nios_mul_pp_stage #(.W(W2)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .up_valid (s1_v),
        .up_data  (s2_d),
        .valid    (sv[j]),
        .data     (sd[j])
      );
    end else begin : g_delay
      nios_mul_pp_stage #(.W(W2)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .up_valid (sv[j-1]),
        .up_data  (sd[j-1]),
        .valid    (sv[j]),
        .data     (sd[j])
      );
    end
  end

  assign out_valid = sv[ND-1];

`ifdef MUL_CELL_ACCUM_EN
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] last_res;
  logic [DATA_W-1:0] shown;
  logic              is_mul;
  logic              out_fire;

  assign is_mul   = (sd[ND-1][DATA_W+1:DATA_W] == OP_MUL);
  assign out_fire = out_valid & out_ready;

  // The accumulated sum is formed at the output, so the delivered value is
  // captured in last_res to keep out_result steady once the beat has left.
  always_comb begin
    if (!out_valid)  shown = last_res;
    else if (is_mul) shown = acc + sd[ND-1][DATA_W-1:0];
    else             shown = sd[ND-1][DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      last_res <= '0;
    end else begin
      if (out_fire) last_res <= shown;
      if (acc_clr)                acc <= '0;
      else if (out_fire & is_mul) acc <= shown;
    end
  end

  assign out_result = shown;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign out_result     = sd[ND-1];
`endif

endmodule

// File: tb/tb_nios_mul_pp_pipe.sv
module tb_nios_mul_pp_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned P  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_src1;
  logic [DW-1:0] in_src2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          acc_clr;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] w;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_last = '0;
  logic [DW-1:0] m_acc  = '0;

  nios_mul_pp_pipe #(.DATA_W(DW), .PIPE_STAGES(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .acc_clr    (acc_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full 2*DW-bit product of the sign- or zero-extended operands.
  function automatic logic [DW-1:0] ref_word(input logic [1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] ea, eb, p;
    ea = (op == 2'b10 || op == 2'b11) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    eb = (op == 2'b11)                ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  function automatic logic [DW-1:0] shown_val(input ent_t e);
`ifdef MUL_CELL_ACCUM_EN
    return (e.op == 2'b00) ? m_acc + e.w : e.w;
`else
    return e.w;
`endif
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_last = '0;
      m_acc  = '0;
    end else begin
      chk("in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, !(out_valid && !out_ready)});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {{(DW-1){1'b0}}, out_valid}, '0);
        end else begin
          logic [DW-1:0] e;
          e = shown_val(q[0]);
          chk("result", out_result, e);
          if (out_ready) begin
            if (q[0].op == 2'b00) m_acc = e;
            void'(q.pop_front());
            m_last = e;
            n_out++;
          end
        end
      end else begin
        chk("hold", out_result, m_last);
      end
      if (acc_clr) m_acc = '0;
      if (in_valid && in_ready) q.push_back('{op: in_op, w: ref_word(in_op, in_src1, in_src2)});
    end
  end

  task automatic drive(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit got;
    got      = 1'b0;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp);
    out_ready = 1'b1;
    drive(op, a, b);
    for (int k = 0; k < int'(P) - 1; k++) begin
      chk({nm, "_early"}, {{(DW-1){1'b0}}, out_valid}, '0);
      @(posedge clk);
      #1;
    end
    chk({nm, "_valid"}, {{(DW-1){1'b0}}, out_valid}, 1);
    chk(nm, out_result, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    bit done;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    out_ready = 1'b1; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready",   {{(DW-1){1'b0}}, in_ready},  1);
    chk("rst_out_valid",  {{(DW-1){1'b0}}, out_valid}, 0);
    chk("rst_out_result", out_result, '0);

    // Hand-computed literals.
    run_one("mul_lit",    2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    run_one("mulxuu_lit", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_one("mulxss_m1",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_one("mulxsu_lit", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_one("mulxss_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mulxsu_neg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    repeat (2) @(posedge clk);
    #1 chk("idle_hold", out_result, 32'h8000_0000);

    // 8-beat stream with 3 cycles of back-pressure mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(2'(i), 32'h1234_0000 + 32'(i * 32'h0101_0101), 32'hF00D_0007 - 32'(i * 13));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (P + 6) @(posedge clk);
    #1;
    chk("stream_count", 32'(n_out - n0), 32'd8);
    chk("stream_drain", 32'(q.size()), 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    drive(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    drive(2'b00, 32'h0000_0077, 32'h0000_0099);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid",  {{(DW-1){1'b0}}, out_valid}, 0);
    chk("flush_result", out_result, '0);
    reset = 1'b0;
    chk("post_rst_ready", {{(DW-1){1'b0}}, in_ready}, 1);
    for (int k = 0; k < int'(P) + 2; k++) begin
      @(posedge clk);
      #1 chk("no_stale", {{(DW-1){1'b0}}, out_valid}, 0);
    end

    // Random ops with random back-pressure.
    done = 1'b0;
    n0   = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          drive(2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !done; k++) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    repeat (P + 6) @(posedge clk);
    #1;
    chk("rand_count", 32'(n_out - n0), 32'd40);

`ifdef MUL_CELL_ACCUM_EN
    do_reset();
    run_one("acc_12", 2'b00, 32'd3, 32'd4, 32'd12);
    run_one("acc_42", 2'b00, 32'd5, 32'd6, 32'd42);
    run_one("acc_bypass", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    run_one("acc_clr_4", 2'b00, 32'd2, 32'd2, 32'd4);
`endif

    repeat (2) @(posedge clk);
    #1 chk("final_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
